mano_seq_ctrl: RTL and testbench

MANO_SEQ_CTRL -- requirements
Module: mano_seq_ctrl

---
 rtl/mano_seq_ctrl_pkg.sv | 17 +
 rtl/mano_seq_ctrl_if.sv | 10 +
 rtl/mano_dec3x8.sv | 8 +
 rtl/mano_seq_ctrl.sv | 51 +++++
 tb/tb_mano_seq_ctrl.sv | 119 +++++++++++
 5 files changed

// File: rtl/mano_seq_ctrl_pkg.sv
// mano_seq_ctrl_pkg: opcodes, per-opcode final timing steps and run-state type for the Mano sequence controller
package mano_seq_ctrl_pkg;
  localparam int SC_W = 3;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;
  localparam logic [SC_W-1:0] FIN_REG = 3'd3;
  localparam logic [SC_W-1:0] FIN_STB = 3'd4;
  localparam logic [SC_W-1:0] FIN_MEM = 3'd5;
  localparam logic [SC_W-1:0] FIN_ISZ = 3'd6;
  typedef enum logic {ST_STOP, ST_RUN} state_t;
endpackage

// File: rtl/mano_seq_ctrl_if.sv
// mano_seq_ctrl_if: instruction-field inputs and timing/decode outputs of the sequence controller
interface mano_seq_ctrl_if;
  import mano_seq_ctrl_pkg::*;
  logic run, hold, ir_i, hlt, j, s, end_ins;
  logic [2:0] ir_op;
  logic [7:0] t, d;
  logic [SC_W-1:0] sc;
  modport master (output run, hold, ir_op, ir_i, hlt, input t, d, j, s, sc, end_ins);
  modport slave (input run, hold, ir_op, ir_i, hlt, output t, d, j, s, sc, end_ins);
endinterface

// File: rtl/mano_dec3x8.sv
// mano_dec3x8: enabled 3-to-8 one-hot decoder
module mano_dec3x8 (
  input  logic [2:0] a,
  input  logic       en,
  output logic [7:0] y
);
  assign y = en ? 8'd1 << a : 8'h00;
endmodule

// File: rtl/mano_seq_ctrl.sv
// mano_seq_ctrl: Mano basic-computer run flag, sequence counter, timing and opcode decode
module mano_seq_ctrl
  import mano_seq_ctrl_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mano_seq_ctrl_if.slave bus
);
  state_t state, state_n;
  logic [SC_W-1:0] sc, sc_n;
  logic [7:0] d, dec_d;
  logic j, s, fin, end_ins, load;
  assign s = state == ST_RUN;
  mano_dec3x8 u_t (.a(sc), .en(s), .y(bus.t));
  mano_dec3x8 u_d (.a(bus.ir_op), .en(1'b1), .y(dec_d));
  assign fin = d[OP_REG] ? sc == FIN_REG :
               (d[OP_STA] | d[OP_BUN]) ? sc == FIN_STB :
               d[OP_ISZ] ? sc == FIN_ISZ : sc == FIN_MEM;
  assign end_ins = s & fin;
  assign load = s & ~bus.hold & (sc == 3'd2);
  always_comb begin
    state_n = state;
    sc_n = sc;
    if (!s) begin
      state_n = bus.run ? ST_RUN : ST_STOP;
      sc_n = '0;
    end else if (!bus.hold) begin
      sc_n = (end_ins || sc == 3'd7) ? '0 : sc + 1'b1;
      if (end_ins && d[OP_REG] && !j && bus.hlt) state_n = ST_STOP;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_STOP;
      sc <= '0;
      d <= '0;
      j <= 1'b0;
    end else begin
      state <= state_n;
      sc <= sc_n;
      if (load) begin
        d <= dec_d;
        j <= bus.ir_i;
      end
    end
  assign bus.d = d;
  assign bus.j = j;
  assign bus.s = s;
  assign bus.sc = sc;
  assign bus.end_ins = end_ins;
endmodule

// File: tb/tb_mano_seq_ctrl.sv
// tb_mano_seq_ctrl: directed vectors feed an expectation queue; a negedge monitor pops and compares
module tb_mano_seq_ctrl;
  typedef struct packed {
    logic [7:0] t;
    logic [7:0] d;
    logic j;
    logic s;
    logic [2:0] sc;
    logic e;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  obs_t q[$];
  obs_t exp_o, act_o;
  int n_chk = 0;
  int n_fail = 0;
  mano_seq_ctrl_if bus();
  mano_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic obs_t mk(input logic [2:0] sc, input logic s, input logic [7:0] d, input logic j, input logic e);
    return obs_t'{s ? 8'd1 << sc : 8'h00, d, j, s, sc, e};
  endfunction
  task automatic cyc(input logic r, input logic h, input logic [2:0] op, input logic ii, input logic hl,
                     input logic [2:0] sc, input logic s, input logic [7:0] d, input logic j, input logic e);
    bus.run = r; bus.hold = h; bus.ir_op = op; bus.ir_i = ii; bus.hlt = hl;
    q.push_back(mk(sc, s, d, j, e));
    @(posedge clk); #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      exp_o = q.pop_front();
      act_o = obs_t'{bus.t, bus.d, bus.j, bus.s, bus.sc, bus.end_ins};
      n_chk++;
      if (act_o !== exp_o)
        begin
          n_fail++;
          $display("FAIL obs #%0d t=%h d=%h j=%b s=%b sc=%0d end=%b, required t=%h d=%h j=%b s=%b sc=%0d end=%b",
                   n_chk, act_o.t, act_o.d, act_o.j, act_o.s, act_o.sc, act_o.e,
                   exp_o.t, exp_o.d, exp_o.j, exp_o.s, exp_o.sc, exp_o.e);
        end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bus.run = 0; bus.hold = 0; bus.ir_op = 0; bus.ir_i = 0; bus.hlt = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0,0,0,0,0, 0,0,8'h00,0,0);
    rst_n = 1'b1;
    cyc(0,0,0,0,0, 0,0,8'h00,0,0);
    cyc(0,1,0,0,0, 0,0,8'h00,0,0);
    cyc(1,0,0,0,0, 0,0,8'h00,0,0);
    // ADD, first instruction after reset: D is still clear until the T2 edge
    cyc(0,0,1,0,0, 0,1,8'h00,0,0);
    cyc(0,0,1,0,0, 1,1,8'h00,0,0);
    cyc(0,0,1,0,0, 2,1,8'h00,0,0);
    cyc(0,0,1,0,0, 3,1,8'h02,0,0);
    cyc(0,0,1,0,0, 4,1,8'h02,0,0);
    cyc(0,0,1,0,0, 5,1,8'h02,0,1);
    // ISZ indirect, with RUN raised while running
    cyc(0,0,6,1,0, 0,1,8'h02,0,0);
    cyc(1,0,6,1,0, 1,1,8'h02,0,0);
    cyc(0,0,6,1,0, 2,1,8'h02,0,0);
    cyc(0,0,6,1,0, 3,1,8'h40,1,0);
    cyc(0,0,6,1,0, 4,1,8'h40,1,0);
    cyc(0,0,6,1,0, 5,1,8'h40,1,0);
    cyc(0,0,6,1,0, 6,1,8'h40,1,1);
    // HLT, with a one-cycle hold on T3 deferring the halt
    cyc(0,0,7,0,1, 0,1,8'h40,1,0);
    cyc(0,0,7,0,1, 1,1,8'h40,1,0);
    cyc(0,0,7,0,1, 2,1,8'h40,1,0);
    cyc(0,1,7,0,1, 3,1,8'h80,0,1);
    cyc(0,0,7,0,1, 3,1,8'h80,0,1);
    cyc(0,0,7,0,0, 0,0,8'h80,0,0);
    cyc(0,1,7,0,0, 0,0,8'h80,0,0);
    cyc(1,0,7,0,0, 0,0,8'h80,0,0);
    // STA with a three-cycle hold on T4
    cyc(0,0,3,0,0, 0,1,8'h80,0,0);
    cyc(0,0,3,0,0, 1,1,8'h80,0,0);
    cyc(0,0,3,0,0, 2,1,8'h80,0,0);
    cyc(0,0,3,0,0, 3,1,8'h08,0,0);
    cyc(0,1,3,0,0, 4,1,8'h08,0,1);
    cyc(0,1,3,0,0, 4,1,8'h08,0,1);
    cyc(0,1,3,0,0, 4,1,8'h08,0,1);
    cyc(0,0,3,0,0, 4,1,8'h08,0,1);
    // LDA indirect, reset asserted mid-T5
    cyc(0,0,2,1,0, 0,1,8'h08,0,0);
    cyc(0,0,2,1,0, 1,1,8'h08,0,0);
    cyc(0,0,2,1,0, 2,1,8'h08,0,0);
    cyc(0,0,2,1,0, 3,1,8'h04,1,0);
    cyc(0,0,2,1,0, 4,1,8'h04,1,0);
    q.push_back(mk(5,1,8'h04,1,1));
    @(negedge clk); #1;
    rst_n = 1'b0;
    q.push_back(mk(0,0,8'h00,0,0));
    @(negedge clk); #1;
    @(posedge clk); #1;
    cyc(0,0,2,1,0, 0,0,8'h00,0,0);
    rst_n = 1'b1;
    cyc(0,0,2,1,0, 0,0,8'h00,0,0);
    cyc(0,0,2,1,0, 0,0,8'h00,0,0);
    cyc(1,0,2,1,0, 0,0,8'h00,0,0);
    cyc(0,0,2,1,0, 0,1,8'h00,0,0);
    cyc(0,0,2,1,0, 1,1,8'h00,0,0);
    repeat (2) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
